// File: rtl/alu_packet_ctrl.sv
// Packet sequencer between the UART AXI-Stream byte links and the shared 32-bit ALU.
// Parses framed packets, echoes payloads or accumulates operands, returns a 4-byte LE result.
module alu_packet_ctrl #(
   parameter logic [7:0] OP_ECHO = 8'hEC,
   parameter logic [7:0] OP_ADD  = 8'hA0,
   parameter logic [7:0] OP_MUL  = 8'hA1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        alu_op_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic        alu_valid_o,
   input  logic        alu_ready_i,
   input  logic [31:0] alu_result_i,
   input  logic        alu_result_valid_i,
   output logic        err_o
);

   localparam logic [3:0] ST_OPC      = 4'd0;
   localparam logic [3:0] ST_RSVD     = 4'd1;
   localparam logic [3:0] ST_LEN_LO   = 4'd2;
   localparam logic [3:0] ST_LEN_HI   = 4'd3;
   localparam logic [3:0] ST_ECHO     = 4'd4;
   localparam logic [3:0] ST_OPND     = 4'd5;
   localparam logic [3:0] ST_ALU_REQ  = 4'd6;
   localparam logic [3:0] ST_ALU_WAIT = 4'd7;
   localparam logic [3:0] ST_SEND     = 4'd8;
   localparam logic [3:0] ST_DRAIN    = 4'd9;

   logic [3:0]  state_q, state_d;
   logic [15:0] cnt_q;
   logic [7:0]  opc_q;
   logic [7:0]  len_lo_q;
   logic [23:0] opnd_q;
   logic [1:0]  bidx_q;
   logic [31:0] acc_q;
   logic        first_q;
   logic        rdy_q;

   logic [15:0] len_w;
   logic [15:0] rem_w;
   logic        echo_ok;
   logic        arith_ok;
   logic [31:0] operand_w;
   logic [7:0]  send_byte;
   logic        s_fire;
   logic        m_fire;
   logic        tx_free;

   assign len_w     = {s_axis_tdata, len_lo_q};
   // Lengths below the header size leave nothing to drain.
   assign rem_w     = (len_w < 16'd4) ? '0 : len_w - 16'd4;
   assign echo_ok   = (opc_q == OP_ECHO) && (len_w >= 16'd4);
   assign arith_ok  = ((opc_q == OP_ADD) || (opc_q == OP_MUL)) &&
                      (len_w >= 16'd8) && (len_w[1:0] == 2'b00);
   assign operand_w = {s_axis_tdata, opnd_q};
   assign tx_free   = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = (state_q == ST_ECHO) ? tx_free : rdy_q;
   assign s_fire    = s_axis_tvalid && s_axis_tready;
   assign m_fire    = m_axis_tvalid && m_axis_tready;

   always_comb begin
      send_byte = acc_q[7:0];
      case (bidx_q)
         2'd1:    send_byte = acc_q[15:8];
         2'd2:    send_byte = acc_q[23:16];
         2'd3:    send_byte = acc_q[31:24];
         default: send_byte = acc_q[7:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OPC:    if (s_fire) state_d = ST_RSVD;
         ST_RSVD:   if (s_fire) state_d = ST_LEN_LO;
         ST_LEN_LO: if (s_fire) state_d = ST_LEN_HI;
         ST_LEN_HI: begin
            if (s_fire) begin
               if (echo_ok)       state_d = (rem_w == '0) ? ST_OPC : ST_ECHO;
               else if (arith_ok) state_d = ST_OPND;
               else               state_d = (rem_w == '0) ? ST_OPC : ST_DRAIN;
            end
         end
         ST_ECHO:   if (s_fire && cnt_q == 16'd1) state_d = ST_OPC;
         ST_OPND: begin
            if (s_fire && bidx_q == 2'd3) begin
               if (!first_q)            state_d = ST_ALU_REQ;
               else if (cnt_q == 16'd1) state_d = ST_SEND;
            end
         end
         ST_ALU_REQ:  if (alu_ready_i) state_d = ST_ALU_WAIT;
         ST_ALU_WAIT: if (alu_result_valid_i) state_d = (cnt_q == '0) ? ST_SEND : ST_OPND;
         ST_SEND:     if (tx_free && bidx_q == 2'd3) state_d = ST_OPC;
         ST_DRAIN:    if (s_fire && cnt_q == 16'd1) state_d = ST_OPC;
         default:     state_d = ST_OPC;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_OPC;
         rdy_q         <= 1'b1;
         cnt_q         <= '0;
         opc_q         <= '0;
         len_lo_q      <= '0;
         opnd_q        <= '0;
         bidx_q        <= '0;
         acc_q         <= '0;
         first_q       <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         alu_op_o      <= 1'b0;
         alu_a_o       <= '0;
         alu_b_o       <= '0;
         alu_valid_o   <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         state_q <= state_d;
         // Registered ready for every state except ECHO, where it follows the tx slot.
         rdy_q   <= !(state_d inside {ST_ALU_REQ, ST_ALU_WAIT, ST_SEND});
         err_o   <= 1'b0;
         if (m_fire) m_axis_tvalid <= 1'b0;
         case (state_q)
            ST_OPC:    if (s_fire) opc_q <= s_axis_tdata;
            ST_LEN_LO: if (s_fire) len_lo_q <= s_axis_tdata;
            ST_LEN_HI: begin
               if (s_fire) begin
                  cnt_q   <= rem_w;
                  bidx_q  <= '0;
                  first_q <= 1'b1;
                  err_o   <= !(echo_ok || arith_ok);
               end
            end
            ST_ECHO: begin
               if (s_fire) begin
                  m_axis_tdata  <= s_axis_tdata;
                  m_axis_tvalid <= 1'b1;
                  cnt_q         <= cnt_q - 16'd1;
               end
            end
            ST_OPND: begin
               if (s_fire) begin
                  opnd_q <= {s_axis_tdata, opnd_q[23:8]};
                  bidx_q <= bidx_q + 2'd1;
                  cnt_q  <= cnt_q - 16'd1;
                  if (bidx_q == 2'd3) begin
                     if (first_q) begin
                        acc_q   <= operand_w;
                        first_q <= 1'b0;
                     end else begin
                        alu_a_o     <= acc_q;
                        alu_b_o     <= operand_w;
                        alu_op_o    <= (opc_q == OP_MUL);
                        alu_valid_o <= 1'b1;
                     end
                  end
               end
            end
            ST_ALU_REQ:  if (alu_ready_i) alu_valid_o <= 1'b0;
            ST_ALU_WAIT: if (alu_result_valid_i) acc_q <= alu_result_i;
            ST_SEND: begin
               if (tx_free) begin
                  m_axis_tdata  <= send_byte;
                  m_axis_tvalid <= 1'b1;
                  bidx_q        <= bidx_q + 2'd1;
               end
            end
            ST_DRAIN: if (s_fire) cnt_q <= cnt_q - 16'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Scoreboard bench for alu_packet_ctrl: stimulus pushes expected tx bytes and ALU requests,
// independent monitors on the tx link, ALU port and err_o pop and compare.
module tb_alu_packet_ctrl;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
   } alu_req_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        alu_op_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic        alu_valid_o;
   logic        alu_ready_i;
   logic [31:0] alu_result_i;
   logic        alu_result_valid_i;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   alu_packet_ctrl #(
      .OP_ECHO(8'hEC),
      .OP_ADD (8'hA0),
      .OP_MUL (8'hA1)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tready     (s_axis_tready),
      .m_axis_tdata      (m_axis_tdata),
      .m_axis_tvalid     (m_axis_tvalid),
      .m_axis_tready     (m_axis_tready),
      .alu_op_o          (alu_op_o),
      .alu_a_o           (alu_a_o),
      .alu_b_o           (alu_b_o),
      .alu_valid_o       (alu_valid_o),
      .alu_ready_i       (alu_ready_i),
      .alu_result_i      (alu_result_i),
      .alu_result_valid_i(alu_result_valid_i),
      .err_o             (err_o)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_tx[$];
   alu_req_t   exp_alu[$];
   int         exp_err = 0;
   int         err_seen = 0;

   // tx backpressure control: stall_len cycles of tready low once the next tvalid shows up
   logic stall_arm = 1'b0;
   int   stall_len = 0;

   int   alu_rdy_delay = 0;
   int   alu_res_delay = 1;
   logic alu_pend = 1'b0;
   int   alu_acc_cnt = 0;

   bq_t pkt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // tx monitor / scoreboard
   initial begin
      int         stall_left;
      logic       tx_hold;
      logic [7:0] tx_held;
      logic [7:0] e;
      stall_left    = 0;
      tx_hold       = 1'b0;
      tx_held       = '0;
      m_axis_tready = 1'b1;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            m_axis_tready = 1'b1;
            stall_left    = 0;
            tx_hold       = 1'b0;
         end else begin
            if (stall_arm && m_axis_tvalid) begin
               stall_arm  = 1'b0;
               stall_left = stall_len;
            end
            if (stall_left > 0) begin
               m_axis_tready = 1'b0;
               stall_left--;
            end else begin
               m_axis_tready = 1'b1;
            end
            if (tx_hold) begin
               chk("tx_hold_valid", 32'(m_axis_tvalid), 32'd1);
               chk("tx_hold_data", 32'(m_axis_tdata), 32'(tx_held));
            end
            tx_hold = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_tx.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected: got byte %h, expected no byte", m_axis_tdata);
               end else begin
                  e = exp_tx.pop_front();
                  chk("tx_byte", 32'(m_axis_tdata), 32'(e));
               end
            end else if (m_axis_tvalid) begin
               tx_hold = 1'b1;
               tx_held = m_axis_tdata;
            end
         end
      end
   end

   // ALU model and request scoreboard
   initial begin
      int          res_cnt;
      int          alu_wait;
      logic        alu_hold;
      alu_req_t    held;
      alu_req_t    e;
      logic [31:0] alu_res;
      res_cnt            = 0;
      alu_wait           = 0;
      alu_hold           = 1'b0;
      held               = '{op: 1'b0, a: '0, b: '0};
      alu_res            = '0;
      alu_ready_i        = 1'b0;
      alu_result_valid_i = 1'b0;
      alu_result_i       = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            alu_ready_i        = 1'b0;
            alu_result_valid_i = 1'b0;
            alu_pend           = 1'b0;
            alu_hold           = 1'b0;
            alu_wait           = 0;
         end else begin
            alu_result_valid_i = 1'b0;
            if (alu_pend) begin
               if (res_cnt == 0) begin
                  alu_result_valid_i = 1'b1;
                  alu_result_i       = alu_res;
                  alu_pend           = 1'b0;
               end else begin
                  res_cnt--;
               end
            end
            if (alu_hold) begin
               chk("alu_hold_valid", 32'(alu_valid_o), 32'd1);
               chk("alu_hold_op", 32'(alu_op_o), 32'(held.op));
               chk("alu_hold_a", alu_a_o, held.a);
               chk("alu_hold_b", alu_b_o, held.b);
            end
            alu_hold = 1'b0;
            if (alu_valid_o && !alu_pend) begin
               if (alu_wait < alu_rdy_delay) begin
                  alu_ready_i = 1'b0;
                  alu_wait++;
               end else begin
                  alu_ready_i = 1'b1;
               end
            end else begin
               alu_ready_i = 1'b0;
            end
            if (alu_valid_o && alu_ready_i) begin
               alu_acc_cnt++;
               if (exp_alu.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL alu_unexpected: got request op=%0d a=%h b=%h, expected none",
                           alu_op_o, alu_a_o, alu_b_o);
               end else begin
                  e = exp_alu.pop_front();
                  chk("alu_op", 32'(alu_op_o), 32'(e.op));
                  chk("alu_a", alu_a_o, e.a);
                  chk("alu_b", alu_b_o, e.b);
               end
               alu_res  = alu_op_o ? alu_a_o * alu_b_o : alu_a_o + alu_b_o;
               alu_pend = 1'b1;
               res_cnt  = alu_res_delay;
               alu_wait = 0;
            end else if (alu_valid_o) begin
               alu_hold = 1'b1;
               held     = '{op: alu_op_o, a: alu_a_o, b: alu_b_o};
            end
         end
      end
   end

   // err_o pulse monitor
   initial begin
      logic err_prev;
      err_prev = 1'b0;
      forever begin
         @(negedge clk_i);
         if (err_o) begin
            err_seen++;
            chk("err_single_cycle", 32'(err_prev), 32'd0);
         end
         err_prev = err_o;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic sync();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int   n;
      logic r;
      n             = 0;
      r             = 1'b0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      do begin
         @(negedge clk_i);
         #1;
         r = s_axis_tready;
         @(posedge clk_i);
         #1;
         n++;
      end while (!r && n < 300);
      if (!r) begin
         checks++;
         errors++;
         $display("FAIL s_axis_accept: byte %h not accepted after %0d cycles, expected acceptance", b, n);
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input bq_t p);
      sync();
      foreach (p[i]) send_byte(p[i]);
   endtask

   task automatic push_tx(input bq_t p);
      foreach (p[i]) exp_tx.push_back(p[i]);
   endtask

   task automatic push_alu(input logic op, input logic [31:0] a, input logic [31:0] b);
      alu_req_t r;
      r = '{op: op, a: a, b: b};
      exp_alu.push_back(r);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || exp_alu.size() != 0 || alu_pend) && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      repeat (6) @(negedge clk_i);
      chk({name, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
      chk({name, "_alu_left"}, 32'(exp_alu.size()), 32'd0);
      chk({name, "_err_count"}, 32'(err_seen), 32'(exp_err));
      exp_tx.delete();
      exp_alu.delete();
      sync();
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_s_tready"}, 32'(s_axis_tready), 32'd1);
      chk({name, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
      chk({name, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
      chk({name, "_alu_valid"}, 32'(alu_valid_o), 32'd0);
      chk({name, "_alu_op"}, 32'(alu_op_o), 32'd0);
      chk({name, "_alu_a"}, alu_a_o, 32'd0);
      chk({name, "_alu_b"}, alu_b_o, 32'd0);
      chk({name, "_err"}, 32'(err_o), 32'd0);
   endtask

   // Reset is asserted between clock edges and checked before the next edge.
   task automatic do_reset(input string name);
      @(posedge clk_i);
      #3;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs(name);
      exp_tx.delete();
      exp_alu.delete();
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      int n;
      int start;

      #1 rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #2;
      check_reset_outputs("por");
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // basic echo
      push_tx('{8'h41, 8'h42, 8'h43});
      pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      send_pkt(pkt);
      wait_idle("echo");

      // add 1 + 2
      push_alu(1'b0, 32'd1, 32'd2);
      push_tx('{8'h03, 8'h00, 8'h00, 8'h00});
      pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt(pkt);
      wait_idle("add");

      // multiply wraps to zero
      push_alu(1'b1, 32'h8000_0000, 32'd2);
      push_tx('{8'h00, 8'h00, 8'h00, 8'h00});
      pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt(pkt);
      wait_idle("mul_wrap");

      // malformed length 10, drained, then an echo must still work
      exp_err++;
      pkt = '{8'hA0, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      send_pkt(pkt);
      push_tx('{8'h55});
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h55};
      send_pkt(pkt);
      wait_idle("malformed");

      // boundary lengths: add with LEN=4 and LEN=2 are errors, echo LEN=4 is silent
      exp_err += 2;
      pkt = '{8'hA0, 8'h00, 8'h04, 8'h00, 8'hA0, 8'h00, 8'h02, 8'h00};
      send_pkt(pkt);
      push_tx('{8'h66});
      pkt = '{8'hEC, 8'h00, 8'h04, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h66};
      send_pkt(pkt);
      wait_idle("len_boundary");

      // unknown opcode with payload
      exp_err++;
      push_tx('{8'h77});
      pkt = '{8'h5A, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
      send_pkt(pkt);
      wait_idle("bad_opcode");

      // echo under 10-cycle tx backpressure
      stall_len = 10;
      stall_arm = 1'b1;
      push_tx('{8'h11, 8'h22, 8'h33, 8'h44});
      pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      send_pkt(pkt);
      wait_idle("echo_stall");

      // three-operand add with wrap, delayed ALU ready, stalled SEND
      alu_rdy_delay = 5;
      stall_len     = 10;
      stall_arm     = 1'b1;
      push_alu(1'b0, 32'd5, 32'hFFFF_FFFF);
      push_alu(1'b0, 32'd4, 32'd3);
      push_tx('{8'h07, 8'h00, 8'h00, 8'h00});
      pkt = '{8'hA0, 8'h00, 8'h10, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h00};
      send_pkt(pkt);
      wait_idle("add3_stall");
      alu_rdy_delay = 0;

      // reset while waiting for the ALU result
      alu_res_delay = 30;
      start = alu_acc_cnt;
      push_alu(1'b0, 32'h0A, 32'h0B);
      pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00};
      send_pkt(pkt);
      n = 0;
      while (alu_acc_cnt == start && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      chk("alu_wait_reached", 32'(alu_acc_cnt != start), 32'd1);
      repeat (3) @(posedge clk_i);
      do_reset("rst_alu_wait");
      alu_res_delay = 1;

      // reset while a result byte is stalled in SEND
      stall_len = 50;
      stall_arm = 1'b1;
      push_alu(1'b0, 32'h0A, 32'h0B);
      send_pkt(pkt);
      n = 0;
      while (!m_axis_tvalid && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      chk("send_reached", 32'(m_axis_tvalid), 32'd1);
      do_reset("rst_send");

      // normal operation after the aborts
      push_alu(1'b0, 32'h0A, 32'h0B);
      push_tx('{8'h15, 8'h00, 8'h00, 8'h00});
      send_pkt(pkt);
      wait_idle("add_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_packet_ctrl.md
# alu_packet_ctrl

Packet sequencer between the UART receive and transmit AXI-Stream byte interfaces and the shared 32-bit ALU. It parses framed command packets arriving from the host, echoes payloads or feeds 32-bit operands to the ALU one at a time, and streams the 4-byte little-endian result back to `uart_tx`. It is the only master of the ALU request port and the only source feeding the transmitter.

## Interface
- `OP_ECHO`, default 8'hEC: opcode that echoes the payload.
- `OP_ADD`, default 8'hA0: opcode for accumulating add.
- `OP_MUL`, default 8'hA1: opcode for accumulating multiply, low 32 bits.
- `clk_i`  in  1  system clock (PLL clock domain).
- `rst_ni`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  8  byte from `uart_rx`.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tready`  out  1  byte accepted when high with `s_axis_tvalid`.
- `m_axis_tdata`  out  8  byte to `uart_tx`.
- `m_axis_tvalid`  out  1  output byte valid.
- `m_axis_tready`  in  1  transmitter ready.
- `alu_op_o`  out  1  0 = add, 1 = mul.
- `alu_a_o`, `alu_b_o`  out  32  ALU operands.
- `alu_valid_o`  out  1  ALU request.
- `alu_ready_i`  in  1  ALU accepts the request.
- `alu_result_i`  in  32  ALU result.
- `alu_result_valid_i`  in  1  one-cycle result strobe.
- `err_o`  out  1  one-cycle pulse on a malformed packet.

## Operation
- Packet: opcode, reserved byte (ignored), LEN_LO, LEN_HI, then payload. LEN is the total packet length including the 4 header bytes.
- States: OPC, RSVD, LEN_LO, LEN_HI, ECHO, OPND, ALU_REQ, ALU_WAIT, SEND, DRAIN.
- Header states accept one byte per cycle whenever `s_axis_tvalid` is high. A 16-bit remaining count is loaded as LEN−4 on LEN_HI.
- Validity check at LEN_HI:
  - Echo is valid for LEN ≥ 4.
  - ADD and MUL are valid for LEN ≥ 8 with (LEN−4) mod 4 = 0.
  - Otherwise, or on an unknown opcode: pulse `err_o` and go to DRAIN, or to OPC if the remaining count is 0.
- ECHO:
  - Each accepted payload byte is registered onto the m_axis output.
  - `s_axis_tready` = !`m_axis_tvalid` || `m_axis_tready`.
  - Go to OPC once the remaining count reaches 0 and the last byte has been accepted. A LEN = 4 echo produces no output.
- OPND:
  - Shift 4 bytes little-endian into the operand register.
  - The first operand loads the accumulator directly, with no ALU request.
  - Each later operand goes to ALU_REQ with `alu_a_o` = acc, `alu_b_o` = operand.
- ALU_REQ: `alu_valid_o` is held high and the operands are held stable until `alu_ready_i`.
- ALU_WAIT: on `alu_result_valid_i`, acc ← `alu_result_i`.
- After the last operand, go to SEND: emit acc bytes [7:0], [15:8], [23:16], [31:24] under the m_axis handshake, then return to OPC.
- DRAIN: accept and discard bytes until the remaining count is 0, then return to OPC.
- `s_axis_tready` is 0 in ALU_REQ, ALU_WAIT and SEND.

## Timing
- Reset values:
  - state = OPC; `s_axis_tready` = 1.
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0.
  - `alu_valid_o` = 0, `alu_op_o` = 0, `alu_a_o` = 0, `alu_b_o` = 0.
  - `err_o` = 0; acc = 0; count = 0.
- Reset asserted mid-packet aborts immediately: any partial output byte is dropped and `m_axis_tvalid` clears asynchronously.
- All outputs are registered. `s_axis_tready` is the only combinational output, and only in ECHO.
- Echo latency: a byte accepted on edge N has `m_axis_tvalid` high after edge N. Back-to-back bytes sustain 1 byte/cycle while `m_axis_tready` = 1.
- m_axis rule: once `m_axis_tvalid` is high, neither it nor `m_axis_tdata` changes until `m_axis_tready` is sampled high.
- ALU rule: `alu_valid_o` drops in the cycle after the handshake. A result strobe outside ALU_WAIT is ignored.
- `alu_result_valid_i` in the same cycle as `alu_ready_i` is legal: the request is accepted and the result is captured on the next ALU_WAIT edge only. The ALU never issues a result in the acceptance cycle.
- Arithmetic is 32-bit modulo: overflow wraps, and MUL keeps the low 32 bits from the ALU.
- The LEN field is 16-bit unsigned; LEN = 16'hFFFF is handled by drain or echo without overflow.
- `err_o` is high for exactly one cycle, in the LEN_HI acceptance cycle + 1.

## Test plan
- Echo: EC 00 07 00 41 42 43 → tx bytes 41 42 43, no `err_o`, back in OPC.
- Add: A0 00 0C 00 01000000 02000000 (ALU model returns a+b) → exactly one ALU request with a = 1, b = 2; tx 03 00 00 00.
- Mul wrap: A1 00 0C 00 00000080 02000000 → ALU request a = 0x80000000, b = 2; tx 00 00 00 00.
- Malformed: A0 00 0A 00 followed by 6 bytes → `err_o` pulses once, no tx output, no ALU request, 6 bytes drained. A following echo packet then works.
- Backpressure: `m_axis_tready` low for 10 cycles during SEND and during ECHO → tdata held stable, no byte lost or duplicated. `alu_ready_i` delayed 5 cycles → `alu_valid_o` held with stable operands.
- Reset mid-operation: `rst_ni` low during ALU_WAIT and during SEND → all outputs at reset values. The next add packet gives the correct result.
